// File: rtl/ym3438_dbg_capture.sv
// ----------------------------------------------------------------------------
// ym3438_dbg_capture
//
// Receiving end of the debug read chains. After the chain's parallel-load
// strobe (load & c1) the block waits for the next c2, then samples the chain
// tail on every c1, packs the bits LSB-first into DATA_WIDTH-bit words and
// pushes each completed word into a first-word-fall-through FIFO.
//
// Parameters:
//   DATA_WIDTH  output word width
//   TOTAL_BITS  chain length (bits per frame)
//   FIFO_DEPTH  FIFO depth in words, power of two, >= 2
//
// Ports:
//   MCLK       sole clock, rising edge
//   IC         synchronous active-low reset
//   c1, c2     two-phase enable strobes (never coincident)
//   load       chain parallel-load signal, qualified by c1
//   dbg_in     serial output of the chain tail
//   rd_en      pop the head word (ignored while empty)
//   err_clr    clear overflow and load_err (a coincident set wins)
//   rd_data    FIFO head word, zero while empty
//   rd_valid   FIFO not empty
//   rd_parity  even parity of the head word (0 unless parity storage built)
//   busy       frame capture in progress
//   overflow   sticky: a completed word was dropped on a full FIFO
//   load_err   sticky: load & c1 arrived while busy
//
// Build option:
//   YM3438_DBG_CAPTURE_PARITY_EN  store a parity bit per word in the FIFO
// ----------------------------------------------------------------------------
module ym3438_dbg_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int TOTAL_BITS = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  MCLK,
    input  logic                  IC,
    input  logic                  c1,
    input  logic                  c2,
    input  logic                  load,
    input  logic                  dbg_in,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_parity,
    output logic                  busy,
    output logic                  overflow,
    output logic                  load_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
    localparam int PW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(TOTAL_BITS - 1);
    localparam logic [PW-1:0] LAST_POS = PW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [PW-1:0]         pos_reg, pos_next;
    logic [DATA_WIDTH-1:0] word_reg, word_next;
    logic                  overflow_reg, load_err_reg;

    logic [DATA_WIDTH-1:0] sample_word;
    logic                  load_hit;
    logic                  sample;
    logic                  last_bit;
    logic                  word_done;
    logic                  load_err_set;

    logic [AW:0]           wr_ptr_reg, rd_ptr_reg;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  fifo_empty, fifo_full;
    logic                  pop, push_ok, overflow_set;

    assign load_hit  = load & c1;
    assign sample    = (state_reg == ST_SHIFT) & c1;
    assign last_bit  = (bit_cnt_reg == LAST_BIT);
    // A word closes on its top bit position or on the final frame bit, so a
    // short last word keeps its unsampled upper bits at zero.
    assign word_done = sample & ((pos_reg == LAST_POS) | last_bit);

    // Current word with this cycle's bit merged in at pos_reg; this is both
    // the value carried forward and the value pushed on completion.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_merge
            assign sample_word[gi] = word_reg[gi] | (dbg_in & (pos_reg == PW'(gi)));
        end
    endgenerate

    // ---------------- capture FSM ----------------
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        pos_next     = pos_reg;
        word_next    = word_reg;
        load_err_set = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (load_hit) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (load_hit) load_err_set = 1'b1;
                if (c2)       state_next   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (load_hit) load_err_set = 1'b1;
                if (c1) begin
                    if (word_done) begin
                        word_next = '0;
                        pos_next  = '0;
                    end else begin
                        word_next = sample_word;
                        pos_next  = pos_reg + PW'(1);
                    end
                    if (last_bit) begin
                        bit_cnt_next = '0;
                        state_next   = ST_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (!IC) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            pos_reg     <= '0;
            word_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            pos_reg     <= pos_next;
            word_reg    <= word_next;
        end
    end

    // ---------------- FIFO ----------------
    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                          (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop          = rd_en & ~fifo_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok      = word_done & (~fifo_full | pop);
    assign overflow_set = word_done & fifo_full & ~pop;

    always_ff @(posedge MCLK) begin
        if (!IC) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage has no reset; the outputs are masked while empty instead.
    always_ff @(posedge MCLK) begin
        if (IC && push_ok) mem[wr_ptr_reg[AW-1:0]] <= sample_word;
    end

    // Fall-through head: the word is visible the cycle after it is written.
    assign rd_valid = ~fifo_empty;
    assign rd_data  = fifo_empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

`ifdef YM3438_DBG_CAPTURE_PARITY_EN
    logic par_mem [FIFO_DEPTH];

    always_ff @(posedge MCLK) begin
        if (IC && push_ok) par_mem[wr_ptr_reg[AW-1:0]] <= ^sample_word;
    end

    assign rd_parity = ~fifo_empty & par_mem[rd_ptr_reg[AW-1:0]];
`else
    assign rd_parity = 1'b0;
`endif

    // ---------------- sticky error flags (set beats clear) ----------------
    always_ff @(posedge MCLK) begin
        if (!IC) begin
            overflow_reg <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            if (overflow_set)  overflow_reg <= 1'b1;
            else if (err_clr)  overflow_reg <= 1'b0;
            if (load_err_set)  load_err_reg <= 1'b1;
            else if (err_clr)  load_err_reg <= 1'b0;
        end
    end

    assign overflow = overflow_reg;
    assign load_err = load_err_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ym3438_dbg_capture.sv
// ----------------------------------------------------------------------------
// Bench for ym3438_dbg_capture with DATA_WIDTH=16, TOTAL_BITS=40,
// FIFO_DEPTH=2. Frames are driven as known 40-bit values; the reference model
// slices the frame value into words arithmetically and keeps the FIFO as a
// bounded queue. Every popped word is compared against the queue head.
// ----------------------------------------------------------------------------
module tb_ym3438_dbg_capture;

    localparam int DW    = 16;
    localparam int NB    = 40;
    localparam int DEPTH = 2;

    logic          MCLK = 1'b0;
    logic          IC, c1, c2, load, dbg_in, rd_en, err_clr;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_parity, busy, overflow, load_err;

    ym3438_dbg_capture #(
        .DATA_WIDTH (DW),
        .TOTAL_BITS (NB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .MCLK      (MCLK),
        .IC        (IC),
        .c1        (c1),
        .c2        (c2),
        .load      (load),
        .dbg_in    (dbg_in),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_parity (rd_parity),
        .busy      (busy),
        .overflow  (overflow),
        .load_err  (load_err)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int passed = 0;

    // reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] popped[$];
    bit            ovf_m, lerr_m, busy_m;

    typedef struct {
        logic [NB-1:0] val;
        int            gap;
        logic [DW-1:0] w0, w1, w2;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic exp_par(input logic [DW-1:0] w);
`ifdef YM3438_DBG_CAPTURE_PARITY_EN
        return ^w;
`else
        return 1'b0;
`endif
    endfunction

    // One MCLK cycle: apply inputs, update the model for the coming edge,
    // then compare registered outputs 1 time unit after the edge.
    task automatic cyc(input bit ic, input bit c1v, input bit c2v, input bit ldv,
                       input bit din, input bit rde, input bit clr,
                       input bit push_v, input logic [DW-1:0] push_w,
                       input bit lerr_set, input bit busy_after);
        bit full, pop, ovf_set;
        logic [DW-1:0] tmp;
        IC = ic; c1 = c1v; c2 = c2v; load = ldv; dbg_in = din;
        rd_en = rde; err_clr = clr;
        if (ic) begin
            if (rde && q.size() > 0) begin
                chk("pop_data", 32'(rd_data), 32'(q[0]));
                chk("pop_parity", 32'(rd_parity), 32'(exp_par(q[0])));
                popped.push_back(q[0]);
            end
            full = (q.size() == DEPTH);
            pop  = rde && (q.size() > 0);
            if (pop) tmp = q.pop_front();
            ovf_set = push_v && full && !pop;
            if (push_v && !ovf_set) q.push_back(push_w);
            if (ovf_set) ovf_m = 1'b1; else if (clr) ovf_m = 1'b0;
            if (lerr_set) lerr_m = 1'b1; else if (clr) lerr_m = 1'b0;
            busy_m = busy_after;
        end else begin
            q.delete();
            ovf_m = 1'b0; lerr_m = 1'b0; busy_m = 1'b0;
        end
        @(posedge MCLK);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("load_err", 32'(load_err), 32'(lerr_m));
        chk("busy", 32'(busy), 32'(busy_m));
    endtask

    function automatic bit rdv(input int mode, input bit push);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom % 2);
            default: return push;
        endcase
    endfunction

    function automatic bit rclr(input bit en);
        return en && ($urandom % 8 == 0);
    endfunction

    task automatic idle(input int mode, input bit rand_clr);
        cyc(1, 0, 0, 0, 0, rdv(mode, 0), rclr(rand_clr), 0, '0, 0, busy_m);
    endtask

    task automatic reset_cycle();
        // other inputs active on purpose: they must be ignored
        cyc(0, 1, 0, 1, 1, 1, 1, 0, '0, 0, 0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_rd_parity", 32'(rd_parity), 32'd0);
    endtask

    // mode: 0 rd low, 1 rd high, 2 rd random, 3 rd only on word-completion
    task automatic run_frame(input logic [NB-1:0] val, input int gap, input int mode,
                             input int inject_k, input bit clr_inject,
                             input int abort_k, input bit rand_clr);
        bit            push, inj, clr;
        logic [DW-1:0] w;
        cyc(1, 1, 0, 1, 0, rdv(mode, 0), rclr(rand_clr), 0, '0, 0, 1);
        for (int g = 0; g < gap; g++) idle(mode, rand_clr);
        cyc(1, 0, 1, 0, 0, rdv(mode, 0), rclr(rand_clr), 0, '0, 0, 1);
        for (int k = 0; k < NB; k++) begin
            for (int g = 0; g < gap; g++) idle(mode, rand_clr);
            push = (k % DW == DW - 1) || (k == NB - 1);
            w    = DW'(val >> (DW * (k / DW)));
            inj  = (k == inject_k);
            clr  = (inj && clr_inject) ? 1'b1 : rclr(rand_clr);
            cyc(1, 1, 0, inj, val[k], rdv(mode, push), clr, push, w, inj, k != NB - 1);
            if (k == abort_k) begin
                reset_cycle();
                return;
            end
            if (k != NB - 1) begin
                for (int g = 0; g < gap; g++) idle(mode, rand_clr);
                cyc(1, 0, 1, 0, 0, rdv(mode, 0), rclr(rand_clr), 0, '0, 0, 1);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++)
            cyc(1, 0, 0, 0, 0, 1, 0, 0, '0, 0, busy_m);
    endtask

    task automatic chk_popped(input string name, input logic [DW-1:0] e[$]);
        chk({name, "_count"}, 32'(popped.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < popped.size(); i++)
            chk({name, "_word"}, 32'(popped[i]), 32'(e[i]));
    endtask

    initial begin
        logic [DW-1:0] exp_q[$];
        logic [NB-1:0] rv;
        int            ik;

        vecs[0] = '{40'h12_3456_789A, 1, 16'h789A, 16'h3456, 16'h0012};
        vecs[1] = '{40'hFF_FFFF_FFFF, 0, 16'hFFFF, 16'hFFFF, 16'h00FF};
        vecs[2] = '{40'h00_0000_0000, 2, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{40'hA5_8001_0001, 0, 16'h0001, 16'h8001, 16'h00A5};
        vecs[4] = '{40'h00_0003_0007, 1, 16'h0007, 16'h0003, 16'h0000};

        IC = 0; c1 = 0; c2 = 0; load = 0; dbg_in = 0; rd_en = 0; err_clr = 0;
        ovf_m = 0; lerr_m = 0; busy_m = 0;
        reset_cycle();

        // table-driven basic frames, drained as they arrive
        for (int i = 0; i < 5; i++) begin
            popped.delete();
            run_frame(vecs[i].val, vecs[i].gap, 1, -1, 0, -1, 0);
            drain();
            exp_q = '{vecs[i].w0, vecs[i].w1, vecs[i].w2};
            chk_popped("frame", exp_q);
        end

        // overflow: third word dropped with rd_en held low
        popped.delete();
        run_frame(40'hAB_CDEF_0123, 1, 0, -1, 0, -1, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        drain();
        exp_q = '{16'h0123, 16'hCDEF};
        chk_popped("ovf_drain", exp_q);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, '0, 0, 0);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // full FIFO with a pop on each completing edge
        popped.delete();
        run_frame(40'h11_2222_3333, 0, 0, -1, 0, -1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, '0, 0, 0);
        run_frame(40'h44_5555_6666, 0, 3, -1, 0, -1, 0);
        chk("fullpop_no_ovf", 32'(overflow), 32'd0);
        drain();
        exp_q = '{16'h3333, 16'h2222, 16'h6666, 16'h5555, 16'h0044};
        chk_popped("fullpop", exp_q);

        // load while busy
        popped.delete();
        run_frame(40'h5A_F00F_1234, 1, 1, 10, 0, -1, 0);
        chk("lerr_set", 32'(load_err), 32'd1);
        drain();
        exp_q = '{16'h1234, 16'hF00F, 16'h005A};
        chk_popped("lerr_frame", exp_q);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, '0, 0, 0);
        chk("lerr_clear", 32'(load_err), 32'd0);
        // set coinciding with clear: set wins
        run_frame(40'h01_0203_0405, 0, 1, 5, 1, -1, 0);
        chk("lerr_set_wins", 32'(load_err), 32'd1);
        drain();
        cyc(1, 0, 0, 0, 0, 0, 1, 0, '0, 0, 0);

        // reset mid-frame then a clean frame
        run_frame(40'hDE_ADBE_EF01, 1, 2, -1, 0, 20, 0);
        popped.delete();
        run_frame(vecs[0].val, 1, 1, -1, 0, -1, 0);
        drain();
        exp_q = '{16'h789A, 16'h3456, 16'h0012};
        chk_popped("after_reset", exp_q);

        // randomized back-to-back frames
        for (int f = 0; f < 20; f++) begin
            rv = {8'($urandom), 32'($urandom)};
            ik = ($urandom % 4 == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            run_frame(rv, int'($urandom_range(0, 2)), 2, ik, 0, -1, 1);
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
